// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer and its prescaler.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StDone   = 2'd3
  } timer_state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider: asserts tick once every divisor+1 enabled clocks.
module tick_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] divisor,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_count;

  assign tick = enable && (r_count == divisor);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer with prescaler, pause/resume, one-shot or auto-reload, and expiry pulse.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 9,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      current,
  output logic                  expired,
  output logic                  running,
  output logic [1:0]            state
);

  timer_state_t          r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_current, w_current_nxt;
  logic [WIDTH-1:0]      r_reload, w_reload_nxt;
  logic [PRESCALE_W-1:0] r_prescale, w_prescale_nxt;
  logic                  r_mode, w_mode_nxt;
  logic                  r_expired, w_expired_nxt;
  logic                  r_running;

  logic w_start_acc, w_pause_acc, w_presc_en, w_presc_clear, w_tick;

  // Priority load > start > pause; start in RUN is a no-op but still masks pause.
  assign w_start_acc = start && !load && (r_state != StRun);
  assign w_pause_acc = pause && !load && !start && (r_state == StRun);
  assign w_presc_en  = (r_state == StRun) && !load && !w_pause_acc;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_presc_clear),
    .enable (w_presc_en),
    .divisor(r_prescale),
    .tick   (w_tick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_current_nxt  = r_current;
    w_reload_nxt   = r_reload;
    w_prescale_nxt = r_prescale;
    w_mode_nxt     = r_mode;
    w_expired_nxt  = 1'b0;
    w_presc_clear  = 1'b0;

    if (load) begin
      w_current_nxt  = load_value;
      w_reload_nxt   = load_value;
      w_prescale_nxt = prescale;
      w_presc_clear  = 1'b1;
      w_state_nxt    = StIdle;
    end else if (w_start_acc) begin
      w_mode_nxt = mode;
      if (r_state == StPaused) begin
        w_state_nxt = StRun;
      end else if (r_current != '0) begin
        w_state_nxt   = StRun;
        w_presc_clear = 1'b1;
      end else begin
        w_state_nxt   = StDone;
        w_expired_nxt = 1'b1;
      end
    end else if (w_pause_acc) begin
      w_state_nxt = StPaused;
    end else if (w_tick) begin
      if (r_current > WIDTH'(1)) begin
        w_current_nxt = r_current - 1'b1;
      end else if (r_mode == MODE_RELOAD && r_reload != '0) begin
        w_current_nxt = r_reload;
        w_expired_nxt = 1'b1;
      end else begin
        w_current_nxt = '0;
        w_state_nxt   = StDone;
        w_expired_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_current  <= '0;
      r_reload   <= '0;
      r_prescale <= '0;
      r_mode     <= MODE_ONESHOT;
      r_expired  <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_current  <= w_current_nxt;
      r_reload   <= w_reload_nxt;
      r_prescale <= w_prescale_nxt;
      r_mode     <= w_mode_nxt;
      r_expired  <= w_expired_nxt;
      r_running  <= (w_state_nxt == StRun);
    end
  end

  assign current = r_current;
  assign expired = r_expired;
  assign running = r_running;
  assign state   = r_state;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench: directed and random stimulus against a cycle-level reference model.
module tb_countdown_timer_ctrl;

  localparam int W  = 9;
  localparam int PW = 8;
  localparam int W16 = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, load, start, pause, mode;
  logic [W-1:0]  load_value, current;
  logic [PW-1:0] prescale;
  logic          expired, running;
  logic [1:0]    state;

  logic           rst16, load16, start16, pause16, mode16;
  logic [W16-1:0] lv16, cur16;
  logic [PW-1:0]  pr16;
  logic           exp16, run16;
  logic [1:0]     st16;

  countdown_timer_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) u_dut (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value), .start(start),
    .pause(pause), .mode(mode), .prescale(prescale), .current(current), .expired(expired),
    .running(running), .state(state)
  );

  countdown_timer_ctrl #(.WIDTH(W16), .PRESCALE_W(PW)) u_dut16 (
    .clock(clock), .reset(rst16), .load(load16), .load_value(lv16), .start(start16),
    .pause(pause16), .mode(mode16), .prescale(pr16), .current(cur16), .expired(exp16),
    .running(run16), .state(st16)
  );

  typedef struct {
    int cur;
    int st;
    int xp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  bit   done16  = 1'b0;

  // Reference model: state 0..3 as in the state list, m_left = clocks until next tick.
  int m_state, m_cur, m_rel, m_p, m_left, m_mode, m_xp;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_cur = 0; m_rel = 0; m_p = 0; m_left = 1; m_mode = 0; m_xp = 0;
  endfunction

  function automatic void model_run_clock();
    m_left = m_left - 1;
    if (m_left == 0) begin
      m_left = m_p + 1;
      if (m_cur > 1) begin
        m_cur = m_cur - 1;
      end else if (m_mode == 1 && m_rel != 0) begin
        m_cur = m_rel;
        m_xp  = 1;
      end else begin
        m_cur   = 0;
        m_xp    = 1;
        m_state = 3;
      end
    end
  endfunction

  function automatic void model_step(bit l, int lv, bit s, bit p, bit md, int pr);
    m_xp = 0;
    if (l) begin
      m_cur = lv; m_rel = lv; m_p = pr; m_state = 0;
    end else if (s && m_state != 1) begin
      m_mode = md;
      if (m_state == 2) begin
        m_state = 1;
      end else if (m_cur != 0) begin
        m_state = 1;
        m_left  = m_p + 1;
      end else begin
        m_state = 3;
        m_xp    = 1;
      end
    end else if (p && !s && m_state == 1) begin
      m_state = 2;
    end else if (m_state == 1) begin
      model_run_clock();
    end
  endfunction

  task automatic drive(input bit l, input int lv, input bit s, input bit p, input bit md,
                       input int pr);
    load = l; load_value = W'(lv); start = s; pause = p; mode = md; prescale = PW'(pr);
    model_step(l, lv, s, p, md, pr);
    sb_q.push_back('{cur: m_cur, st: m_state, xp: m_xp});
  endtask

  task automatic cyc(input bit l, input int lv, input bit s, input bit p, input bit md,
                     input int pr);
    @(negedge clock);
    drive(l, lv, s, p, md, pr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Monitor: every clock the DUT presents a new registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (mon_en) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: got no expected entry, required one at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("current", int'(current), e.cur);
          chk("state", int'(state), e.st);
          chk("expired", int'(expired), e.xp);
          chk("running", int'(running), (e.st == 1) ? 1 : 0);
        end
      end
    end
  end

  task automatic random_cycle();
    int r, pick, lv;
    r = $urandom_range(0, 99);
    pick = $urandom_range(0, 9);
    lv = (pick == 0) ? 0 : (pick == 1) ? $urandom_range(0, 511) : $urandom_range(1, 12);
    if (r < 3) cyc(1'b1, lv, 1'b0, 1'b0, 1'b0, $urandom_range(0, 3));
    else if (r < 4) cyc(1'b1, lv, 1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    else if (r < 12) cyc(1'b0, 0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 0);
    else if (r < 16) cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    else cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; load = 0; start = 0; pause = 0; mode = 0; load_value = '0; prescale = '0;
    rst16 = 1'b1; load16 = 0; start16 = 0; pause16 = 0; mode16 = 0; lv16 = '0; pr16 = '0;
    model_reset();
    #3;
    chk("reset_current", int'(current), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_expired", int'(expired), 0);
    chk("reset_running", int'(running), 0);
    @(negedge clock);
    reset = 1'b0;
    rst16 = 1'b0;
    mon_en = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

    fork
      begin : main_seq
        // One-shot 255 at P=0
        cyc(1'b1, 255, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        idle(260);
        // Auto-reload 4 at P=3
        cyc(1'b1, 4, 1'b0, 1'b0, 1'b0, 3);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 0);
        idle(70);
        // Pause/resume
        cyc(1'b1, 10, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        idle(3);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        idle(20);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        idle(10);
        // Pause on the tick edge at current=1, then load coincident with expiry
        cyc(1'b1, 2, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        idle(1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        idle(3);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 5, 1'b0, 1'b0, 1'b0, 0);
        idle(2);
        // Start with zero count
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        idle(3);
        // Asynchronous reset mid-run at current=100
        cyc(1'b1, 200, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        idle(100);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("async_current", int'(current), 0);
        chk("async_state", int'(state), 0);
        chk("async_running", int'(running), 0);
        model_reset();
        #1 reset = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        idle(2);
        while (!done16) random_cycle();
      end
      begin : wide_seq
        @(negedge clock);
        load16 = 1'b1; lv16 = '1; pr16 = '0;
        @(negedge clock);
        load16 = 1'b0; start16 = 1'b1; mode16 = 1'b0;
        @(posedge clock);
        #1;
        chk("w16_start_current", int'(cur16), 65535);
        chk("w16_start_state", int'(st16), 1);
        @(negedge clock);
        start16 = 1'b0;
        for (int i = 1; i <= 65535; i++) begin
          if (i > 1) @(posedge clock);
          else @(posedge clock);
          #1;
          chk("w16_current", int'(cur16), 65535 - i);
          chk("w16_expired", int'(exp16), (i == 65535) ? 1 : 0);
        end
        chk("w16_done_state", int'(st16), 3);
        chk("w16_done_running", int'(run16), 0);
        @(posedge clock);
        #1;
        chk("w16_no_wrap", int'(cur16), 0);
        chk("w16_single_expiry", int'(exp16), 0);
        done16 = 1'b1;
      end
    join

    @(negedge clock);
    mon_en = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Parametrised countdown timer, the successor to the fixed 9-bit `counter`. It adds a configurable width, a clock prescaler, pause/resume, a one-shot or auto-reload mode, and a single-cycle expiry pulse. It sits between the control/register logic that loads and starts it and the display or interrupt logic that consumes `current` and `expired`.

## Interface
- `WIDTH`, default 9: width of the count value.
- `PRESCALE_W`, default 8: width of the prescaler divisor.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `load`  in  1: load `load_value` into `current` and the reload register.
- `load_value`  in  WIDTH: start/reload count.
- `start`  in  1: begin or resume counting.
- `pause`  in  1: freeze counting.
- `mode`  in  1: 0 = one-shot, 1 = auto-reload. Sampled when `start` is accepted.
- `prescale`  in  PRESCALE_W: a tick occurs every `prescale`+1 clocks. Sampled on `load`.
- `current`  out  WIDTH: present count.
- `expired`  out  1: one-cycle pulse at expiry.
- `running`  out  1: high in RUN.
- `state`  out  2: FSM state, for debug.

## Operation
- States: IDLE=0, RUN=1, PAUSED=2, DONE=3.
- Per-cycle input priority: `load` > `start` > `pause`. Lower-priority inputs are ignored in that cycle.
- `load`, any state:
  - `current` and `reload` ← `load_value`; `prescale` is latched.
  - Prescaler count clears to 0.
  - State → IDLE.
- `start`:
  - IDLE or DONE with `current` ≠ 0 → RUN, prescaler cleared. The mode is latched.
  - IDLE or DONE with `current` = 0 → DONE, `expired` pulses once.
  - PAUSED → RUN; the prescaler count and `current` are preserved.
  - `start` in RUN is ignored.
- `pause`: RUN → PAUSED. In any other state it is ignored.
- Tick: in RUN, `tick` = (prescaler count == latched `prescale`). On a tick the prescaler count wraps to 0; otherwise it increments. In any non-RUN state the prescaler holds.
- On a tick in RUN:
  - `current` > 1: `current` ← `current` − 1.
  - `current` = 1, one-shot: `current` ← 0, state → DONE, `expired` ← 1.
  - `current` = 1, auto-reload with `reload` ≠ 0: `current` ← `reload`, stay in RUN, `expired` ← 1.
- Auto-reload never displays 0 while running.
- Arithmetic is unsigned, WIDTH bits. Because 0 is never decremented, `current` never wraps.
- Simultaneous `pause` and tick: pause wins, with no decrement and no expiry.
- Simultaneous `load` and tick/expiry: load wins and `expired` stays low.
- The maximum count 2^WIDTH−1 is legal.

## Timing
- Reset values: `current`=0, `reload`=0, prescaler count=0, latched `prescale`=0, `expired`=0, `running`=0, `state`=IDLE.
- All outputs are registered. `running` and `state` update on the edge that accepts the command.
- Let `start` be sampled at edge k, with `load_value`=N and `prescale`=P:
  - First decrement at edge k+P+1.
  - `current` reaches 0 (one-shot) or reloads (auto-reload) at edge k+N·(P+1).
  - `expired` is high for exactly the cycle following that edge.
- Auto-reload period is N·(P+1) clocks. `expired` is one cycle wide every period.
- An asserted `reset` at any point forces reset values immediately, independent of `clock`. After deassertion the block is in IDLE with `current`=0 until the next `load`.

## Structure
- Package `timer_pkg` holds:
  - State enum `timer_state_t` (2 bits, values as listed above).
  - Mode constants `MODE_ONESHOT`=0 and `MODE_RELOAD`=1.
- Sub-module `tick_prescaler`:
  - Parameter: `PRESCALE_W`.
  - Inputs: `clock`, `reset`, `clear`, `enable`, `divisor`.
  - Output: `tick`.
  - Counter that clears on `clear`, holds when `enable` is low, and asserts `tick` on terminal count.
- Top level contains the FSM, the `current`/`reload` registers, and the expiry logic.

## Test plan
- WIDTH=9, P=0, load 255, one-shot start: `current` steps 255→0 one per clock; `expired` pulses once at cycle 255; state=DONE; `running`=0.
- P=3, load 4, auto-reload: `expired` pulses every 16 clocks; `current` sequence is 4,3,2,1,4,…; 0 never appears.
- Load 10, P=0, start, pause after 3 ticks: `current`=7 holds for 20 clocks; `start` resumes to 0 after exactly 7 more ticks.
- `pause` on the tick edge at `current`=1: no expiry, `current` stays 1. `load` 5 coincident with the expiry tick: `current`=5, state=IDLE, `expired` stays low.
- `start` with `current`=0 gives DONE plus one `expired` pulse. Async `reset` mid-RUN at `current`=100 gives immediate `current`=0, IDLE, `running`=0, without a clock edge.
- WIDTH=16, load 65535, P=0: full countdown with a single `expired` and no wrap to 65535.
